// File: rtl/if_fetch_pkg.sv
// Shared types and widths for the instruction-fetch stage.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package if_fetch_pkg;

    localparam int ADDR_LEN = 32;
    localparam int INST_LEN = 32;

    typedef enum logic {
        IF_LOOKUP = 1'b0,
        IF_MISS   = 1'b1
    } if_state_t;

endpackage

// File: rtl/if_icache.sv
// Direct-mapped one-word-per-line icache: combinational read, single write port.
// Latency: read is combinational; a write is visible on the cycle after its edge.
// Backpressure: none; the owner qualifies wr_en.
module if_icache
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_LEN,
    parameter int INST_W = INST_LEN,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_hit,
    output logic [INST_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [INST_W-1:0] wr_data
);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam int LINES = 1 << IDX_W;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [INST_W-1:0] data_mem [LINES];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             unused_byte_bits;

    assign rd_idx = rd_addr[IDX_W+1:2];
    assign rd_tag = rd_addr[ADDR_W-1:IDX_W+2];
    assign wr_idx = wr_addr[IDX_W+1:2];
    assign wr_tag = wr_addr[ADDR_W-1:IDX_W+2];
    // Fetches are word-granular; byte offset bits never select anything.
    assign unused_byte_bits = ^{rd_addr[1:0], wr_addr[1:0]};

    assign rd_hit  = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_data = data_mem[rd_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns PC, looks it up in the icache, refills misses over req/ack.
// Latency: hit offered combinationally; miss costs memory latency + 1 cycle.
// Backpressure: if_id_stall holds PC on a hit; rdy=0 freezes all state.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int              ADDR_W   = ADDR_LEN,
    parameter int              INST_W   = INST_LEN,
    parameter int              IDX_W    = 6,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_id_stall,
    input  logic              jump_or_not,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              if_stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INST_W-1:0] mem_data
);
    if_state_t         state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] miss_addr;
    logic              hit;
    logic [INST_W-1:0] line_data;
    logic              fill_en;

    // The fill always targets the address that missed, even if PC was redirected.
    assign fill_en = rdy && (state == IF_MISS) && mem_ack;

    if_icache #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .IDX_W  (IDX_W)
    ) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (pc),
        .rd_hit  (hit),
        .rd_data (line_data),
        .wr_en   (fill_en),
        .wr_addr (miss_addr),
        .wr_data (mem_data)
    );

    assign if_pc    = pc;
    assign if_stall = !((state == IF_LOOKUP) && hit);
    assign if_inst  = if_stall ? '0 : line_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= RESET_PC;
            state     <= IF_LOOKUP;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            miss_addr <= '0;
        end else if (rdy) begin
            case (state)
                IF_LOOKUP: begin
                    if (jump_or_not) begin
                        pc <= jump_target;
                    end else if (hit) begin
                        if (!if_id_stall) begin
                            pc <= pc + ADDR_W'(4);
                        end
                    end else begin
                        miss_addr <= pc;
                        mem_req   <= 1'b1;
                        mem_addr  <= {pc[ADDR_W-1:2], 2'b00};
                        state     <= IF_MISS;
                    end
                end
                IF_MISS: begin
                    // A redirect never aborts the outstanding request.
                    if (jump_or_not) begin
                        pc <= jump_target;
                    end
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IF_LOOKUP;
                    end
                end
                default: state <= IF_LOOKUP;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: reset, cold/warm fetch, stall, jump-in-miss, conflict, rdy.
module tb_if_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_id_stall;
    logic        jump_or_not;
    logic [31:0] jump_target;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;

    int checks   = 0;
    int failures = 0;

    if_fetch #(
        .ADDR_W   (32),
        .INST_W   (32),
        .IDX_W    (6),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .if_id_stall (if_id_stall),
        .jump_or_not (jump_or_not),
        .jump_target (jump_target),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_stall    (if_stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fill(input logic [31:0] data);
        mem_ack  = 1'b1;
        mem_data = data;
        tick();
        mem_ack  = 1'b0;
        mem_data = '0;
    endtask

    task automatic jump(input logic [31:0] target);
        jump_or_not = 1'b1;
        jump_target = target;
        tick();
        jump_or_not = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] pc, input logic stall,
                              input logic [31:0] inst);
        chk({tag, "_pc"}, if_pc, pc);
        chk({tag, "_stall"}, {31'd0, if_stall}, {31'd0, stall});
        chk({tag, "_inst"}, if_inst, inst);
    endtask

    task automatic expect_mem(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, "_req"}, {31'd0, mem_req}, {31'd0, req});
        chk({tag, "_addr"}, mem_addr, addr);
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; if_id_stall = 1'b0; jump_or_not = 1'b0;
        jump_target = '0; mem_ack = 1'b0; mem_data = '0;

        // Reset state
        tick();
        expect_out("rst", 32'h0, 1'b1, 32'h0);
        expect_mem("rst", 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        expect_mem("cold_req", 1'b1, 32'h0);

        // Cold miss, ack on the third cycle of the request
        tick();
        expect_mem("cold_hold1", 1'b1, 32'h0);
        tick();
        expect_mem("cold_hold2", 1'b1, 32'h0);
        chk("cold_stall_wait", {31'd0, if_stall}, 32'd1);
        fill(32'h0000_0013);
        expect_out("cold_hit", 32'h0, 1'b0, 32'h0000_0013);
        chk("cold_req_drop", {31'd0, mem_req}, 32'd0);
        tick();
        expect_out("adv4", 32'h4, 1'b1, 32'h0);
        tick();
        expect_mem("miss4", 1'b1, 32'h4);

        // Warm up 0x4..0xC, stall IF/ID at 0x8
        fill(32'h0040_0093);
        expect_out("hit4", 32'h4, 1'b0, 32'h0040_0093);
        tick();
        tick();
        expect_mem("miss8", 1'b1, 32'h8);
        fill(32'h0000_0022);
        expect_out("hit8", 32'h8, 1'b0, 32'h0000_0022);
        if_id_stall = 1'b1;
        tick();
        expect_out("stall8a", 32'h8, 1'b0, 32'h0000_0022);
        chk("stall8a_req", {31'd0, mem_req}, 32'd0);
        tick();
        expect_out("stall8b", 32'h8, 1'b0, 32'h0000_0022);
        chk("stall8b_req", {31'd0, mem_req}, 32'd0);
        if_id_stall = 1'b0;
        tick();
        chk("release_pc", if_pc, 32'hC);
        tick();
        expect_mem("missC", 1'b1, 32'hC);
        fill(32'h0000_0033);
        expect_out("hitC", 32'hC, 1'b0, 32'h0000_0033);
        jump(32'h0);
        expect_out("loop0", 32'h0, 1'b0, 32'h0000_0013);
        tick();
        expect_out("loop4", 32'h4, 1'b0, 32'h0040_0093);

        // Jump during a miss does not abort the outstanding fill
        jump(32'h10);
        expect_out("j10", 32'h10, 1'b1, 32'h0);
        tick();
        expect_mem("miss10", 1'b1, 32'h10);
        jump(32'h100);
        chk("jmiss_pc", if_pc, 32'h100);
        expect_mem("jmiss_hold1", 1'b1, 32'h10);
        tick();
        expect_mem("jmiss_hold2", 1'b1, 32'h10);
        fill(32'h0000_0044);
        expect_out("after_fill10", 32'h100, 1'b1, 32'h0);
        chk("after_fill10_req", {31'd0, mem_req}, 32'd0);
        tick();
        expect_mem("miss100", 1'b1, 32'h100);

        // Conflict: 0x100 evicts 0x0 from index 0
        fill(32'h0000_0055);
        expect_out("hit100", 32'h100, 1'b0, 32'h0000_0055);
        jump(32'h0);
        expect_out("evicted0", 32'h0, 1'b1, 32'h0);
        tick();
        expect_mem("remiss0", 1'b1, 32'h0);
        fill(32'h0000_0013);
        expect_out("refill0", 32'h0, 1'b0, 32'h0000_0013);
        jump(32'h10);
        expect_out("line10", 32'h10, 1'b0, 32'h0000_0044);

        // rdy=0 mid-hit freezes everything, including redirects
        rdy = 1'b0;
        jump_or_not = 1'b1;
        jump_target = 32'h200;
        for (int i = 0; i < 4; i++) tick();
        expect_out("frz_hit", 32'h10, 1'b0, 32'h0000_0044);
        expect_mem("frz_hit", 1'b0, 32'h0);
        rdy = 1'b1;
        jump_or_not = 1'b0;
        tick();
        expect_out("thaw14", 32'h14, 1'b1, 32'h0);
        tick();
        expect_mem("miss14", 1'b1, 32'h14);

        // rdy=0 mid-miss
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        expect_out("frz_miss", 32'h14, 1'b1, 32'h0);
        expect_mem("frz_miss", 1'b1, 32'h14);
        rdy = 1'b1;
        fill(32'h0000_0066);
        expect_out("hit14", 32'h14, 1'b0, 32'h0000_0066);

        // Asynchronous reset in the middle of a miss
        tick();
        tick();
        expect_mem("miss18", 1'b1, 32'h18);
        rst = 1'b0;
        #1;
        expect_out("arst", 32'h0, 1'b1, 32'h0);
        expect_mem("arst", 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
